// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch responder
package imem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [31:0] ERR_INSTR = 32'h0000_0000;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/imem_store.sv
// imem_store: 1R1W synchronous instruction word array, read-before-write
module imem_store #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];
    // write and read on the same edge; nonblocking update returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: fixed-latency instruction fetch responder with preloadable store
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [31:0]           served_cnt
);
    localparam int CW = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("imem_fetch_responder: LATENCY must be >= 1");
    end

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] off;
    logic              err;
    logic              enter_resp;
    logic              hit_q;
    logic [31:0]       rdata;

    assign req_ready  = (state == IDLE);
    assign resp_instr = hit_q ? rdata : ERR_INSTR;

    // decode the address that is about to be answered; with LATENCY==1 that is the live request
    always_comb begin
        cur_addr   = (state == IDLE) ? req_addr : addr_q;
        off        = cur_addr - BASE_ADDR;
        err        = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) || (off[ADDR_W-1:DEPTH_LOG2+2] != '0);
        enter_resp = (state == IDLE && req_valid && LATENCY == 1) || (state == WAIT && cnt == '0);
    end

    imem_store #(.DEPTH_LOG2(DEPTH_LOG2)) u_store (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (enter_resp && !err),
        .raddr (off[DEPTH_LOG2+1:2]),
        .rdata (rdata)
    );

    // request/response FSM; the store word is captured on the same edge that enters RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            hit_q      <= 1'b0;
            served_cnt <= '0;
        end else begin
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= err;
                hit_q      <= !err;
            end
            case (state)
                IDLE: if (req_valid) begin
                    addr_q <= req_addr;
                    state  <= (LATENCY == 1) ? RESP : WAIT;
                    cnt    <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
                end
                WAIT: if (cnt == '0) state <= RESP;
                      else cnt <= cnt - 1'b1;
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    served_cnt <= served_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
